// File: rtl/cursor_select_ctrl.sv
// cursor_select_ctrl: debounces the move/select buttons, steps a cursor over the
// free cells of a 3x3 board, and issues one-cycle placement commands.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   btn_move, btn_sel   raw buttons, asynchronous to clk
//   game_active         1 = game running; dropping it returns to IDLE
//   occupied[8:0]       bit i = 1 -> cell i taken
//   player_pos[3:0]     cursor cell 0..8
//   player_enable       1 = draw cursor
//   place_valid         one-cycle placement command
//   place_pos[3:0]      cell to place (0 unless place_valid)
//   place_player        0 = X, 1 = O (0 unless place_valid)
//   timeout             one-cycle pulse with a forced placement
module cursor_select_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250000,
   parameter int TIMEOUT_CYCLES  = 250000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_move,
   input  logic       btn_sel,
   input  logic       game_active,
   input  logic [8:0] occupied,
   output logic [3:0] player_pos,
   output logic       player_enable,
   output logic       place_valid,
   output logic [3:0] place_pos,
   output logic       place_player,
   output logic       timeout
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEEK    = 2'd1,
      WAIT_IN = 2'd2,
      PLACE   = 2'd3
   } state_t;

   // bit 0 = move, bit 1 = select
   logic [1:0]    w_btn;
   logic [1:0]    r_sync1;
   logic [1:0]    r_sync2;
   logic [1:0]    r_db;
   logic [1:0]    r_db_d;
   logic [DW-1:0] r_cnt [2];
   logic [1:0]    w_ev;

   state_t        r_state;
   state_t        w_state_nxt;
   logic [3:0]    r_cursor;
   logic [3:0]    w_cursor_nxt;
   logic [3:0]    w_cursor_inc;
   logic          r_turn;
   logic          w_turn_nxt;
   logic [TW-1:0] r_timer;
   logic [TW-1:0] w_timer_nxt;
   logic          r_to;
   logic          w_to_nxt;
   logic          w_move_ev;
   logic          w_sel_ev;

   assign w_btn = {btn_sel, btn_move};

   // Synchronizer and debouncer: the level flips only after the synced
   // input disagrees with it for DEBOUNCE_CYCLES consecutive cycles.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_db    <= '0;
         r_db_d  <= '0;
         for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
      end else begin
         r_sync1 <= w_btn;
         r_sync2 <= r_sync1;
         r_db_d  <= r_db;
         for (int i = 0; i < 2; i++) begin
            if (r_sync2[i] != r_db[i]) begin
               if (r_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
                  r_db[i]  <= r_sync2[i];
                  r_cnt[i] <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + DW'(1);
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   // One event per press: rising edge of the debounced level.
   assign w_ev      = r_db & ~r_db_d;
   assign w_move_ev = w_ev[0];
   assign w_sel_ev  = w_ev[1];

   assign w_cursor_inc = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_cursor <= '0;
         r_turn   <= 1'b0;
         r_timer  <= '0;
         r_to     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_cursor <= w_cursor_nxt;
         r_turn   <= w_turn_nxt;
         r_timer  <= w_timer_nxt;
         r_to     <= w_to_nxt;
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_cursor_nxt  = r_cursor;
      w_turn_nxt    = r_turn;
      w_timer_nxt   = r_timer;
      w_to_nxt      = 1'b0;
      player_pos    = r_cursor;
      player_enable = 1'b0;
      place_valid   = 1'b0;
      place_pos     = 4'd0;
      place_player  = 1'b0;
      timeout       = 1'b0;

      unique case (r_state)
         IDLE: begin
            if (game_active) begin
               w_cursor_nxt = 4'd0;
               w_turn_nxt   = 1'b0;
               w_state_nxt  = SEEK;
            end
         end
         SEEK: begin
            if (occupied == 9'h1FF) begin
               w_state_nxt = IDLE;
            end else if (occupied[r_cursor]) begin
               w_cursor_nxt = w_cursor_inc;
            end else begin
               w_timer_nxt = '0;
               w_state_nxt = WAIT_IN;
            end
         end
         WAIT_IN: begin
            player_enable = 1'b1;
            w_timer_nxt   = r_timer + TW'(1);
            // Select has priority; a simultaneous move is dropped.
            if (w_sel_ev) begin
               w_state_nxt = occupied[r_cursor] ? SEEK : PLACE;
            end else if (w_move_ev) begin
               w_cursor_nxt = w_cursor_inc;
               w_state_nxt  = SEEK;
            end else if (r_timer == TW'(TIMEOUT_CYCLES - 1)) begin
               w_to_nxt    = 1'b1;
               w_state_nxt = PLACE;
            end
         end
         PLACE: begin
            player_enable = 1'b1;
            place_valid   = 1'b1;
            place_pos     = r_cursor;
            place_player  = r_turn;
            timeout       = r_to;
            w_turn_nxt    = ~r_turn;
            w_state_nxt   = SEEK;
         end
         default: w_state_nxt = IDLE;
      endcase

      // Losing the game overrides everything; the state register drives
      // the placement outputs so nothing is issued after this edge.
      if (!game_active) begin
         w_state_nxt = IDLE;
         w_to_nxt    = 1'b0;
      end
   end

endmodule

// File: tb/tb_cursor_select_ctrl.sv
// tb_cursor_select_ctrl: directed test of cursor_select_ctrl with
// DEBOUNCE_CYCLES = 4 and TIMEOUT_CYCLES = 50.
module tb_cursor_select_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_move;
   logic       btn_sel;
   logic       game_active;
   logic [8:0] occupied;
   logic [3:0] player_pos;
   logic       player_enable;
   logic       place_valid;
   logic [3:0] place_pos;
   logic       place_player;
   logic       timeout;

   logic [8:0] board;
   logic [8:0] pre;
   logic       clr_board;

   int n_chk = 0;
   int n_err = 0;
   int n_place = 0;
   int n_to = 0;
   int last_pos = 0;
   int last_player = 0;

   always #5 clk = ~clk;

   cursor_select_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .TIMEOUT_CYCLES (50)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .btn_move     (btn_move),
      .btn_sel      (btn_sel),
      .game_active  (game_active),
      .occupied     (occupied),
      .player_pos   (player_pos),
      .player_enable(player_enable),
      .place_valid  (place_valid),
      .place_pos    (place_pos),
      .place_player (place_player),
      .timeout      (timeout)
   );

   // Board register model: a cell becomes taken at the edge ending place_valid.
   assign occupied = board | pre;

   always @(posedge clk) begin
      if (rst || clr_board) board <= '0;
      else if (place_valid) board[place_pos] <= 1'b1;
   end

   always @(posedge clk) begin
      if (!rst && place_valid) begin
         n_place     = n_place + 1;
         last_pos    = int'(place_pos);
         last_player = int'(place_player);
         if (timeout) n_to = n_to + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk = n_chk + 1;
      if (got !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   task automatic press(input bit sel, input int hold);
      if (sel) btn_sel = 1'b1;
      else btn_move = 1'b1;
      repeat (hold) @(negedge clk);
      btn_sel  = 1'b0;
      btn_move = 1'b0;
      repeat (12) @(negedge clk);
   endtask

   initial begin
      bit found;
      rst         = 1'b1;
      btn_move    = 1'b0;
      btn_sel     = 1'b0;
      game_active = 1'b0;
      pre         = '0;
      clr_board   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_en", 32'(player_enable), 0);
      chk("rst_pos", 32'(player_pos), 0);
      chk("rst_pv", 32'(place_valid), 0);
      chk("rst_pp", 32'(place_pos), 0);
      chk("rst_pl", 32'(place_player), 0);
      chk("rst_to", 32'(timeout), 0);
      rst = 1'b0;
      @(negedge clk);

      // Start: cursor shown at 0 within 3 cycles.
      game_active = 1'b1;
      repeat (3) @(negedge clk);
      chk("start_en", 32'(player_enable), 1);
      chk("start_pos", 32'(player_pos), 0);
      chk("start_np", 32'(n_place), 0);

      // Held move skips cells 1 and 2, exactly one step.
      pre = 9'b000000110;
      press(1'b0, 10);
      chk("move_skip", 32'(player_pos), 3);
      chk("move_np", 32'(n_place), 0);

      // 2-cycle glitch is filtered.
      btn_move = 1'b1;
      repeat (2) @(negedge clk);
      btn_move = 1'b0;
      repeat (12) @(negedge clk);
      chk("glitch", 32'(player_pos), 3);

      // Select at 4 -> X placed at 4.
      press(1'b0, 10);
      chk("to4", 32'(player_pos), 4);
      press(1'b1, 10);
      chk("pl1_n", 32'(n_place), 1);
      chk("pl1_pos", 32'(last_pos), 4);
      chk("pl1_ply", 32'(last_player), 0);
      chk("pl1_to", 32'(n_to), 0);
      chk("after_pl1", 32'(player_pos), 5);

      // Next placement is O.
      press(1'b1, 10);
      chk("pl2_n", 32'(n_place), 2);
      chk("pl2_pos", 32'(last_pos), 5);
      chk("pl2_ply", 32'(last_player), 1);

      // Wrap 8 -> 0 with cell 0 free.
      press(1'b0, 10);
      press(1'b0, 10);
      chk("at8a", 32'(player_pos), 8);
      press(1'b0, 10);
      chk("wrap0", 32'(player_pos), 0);

      // Wrap 8 -> 0 -> 1 with cell 0 taken.
      pre = 9'b000000001;
      press(1'b0, 10);
      chk("to1", 32'(player_pos), 1);
      for (int i = 0; i < 5; i++) press(1'b0, 10);
      chk("at8b", 32'(player_pos), 8);
      press(1'b0, 10);
      chk("wrap1", 32'(player_pos), 1);

      // Timeout at cell 2.
      press(1'b0, 10);
      chk("to2", 32'(player_pos), 2);
      found = 1'b0;
      for (int i = 0; i < 80 && !found; i++) begin
         @(negedge clk);
         if (place_valid) begin
            found = 1'b1;
            chk("tmo_pulse", 32'(timeout), 1);
            chk("tmo_pos", 32'(place_pos), 2);
            chk("tmo_ply", 32'(place_player), 0);
         end
      end
      chk("tmo_seen", 32'(found), 1);
      @(negedge clk);
      chk("tmo_cnt", 32'(n_to), 1);

      // Full board -> IDLE.
      pre = 9'h1FF;
      press(1'b0, 10);
      chk("full_en", 32'(player_enable), 0);
      chk("full_np", 32'(n_place), 3);

      // Restart, then drop game_active mid-WAIT_IN.
      pre = '0;
      clr_board = 1'b1;
      @(negedge clk);
      clr_board = 1'b0;
      repeat (4) @(negedge clk);
      chk("re_en", 32'(player_enable), 1);
      chk("re_pos", 32'(player_pos), 0);
      game_active = 1'b0;
      @(negedge clk);
      chk("drop_en", 32'(player_enable), 0);
      repeat (3) @(negedge clk);
      chk("drop_np", 32'(n_place), 3);
      chk("drop_pv", 32'(place_valid), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
